// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared pipeline constants for the hazard controller: FSM state encoding,
// default memory-wait limit and the pipeline-register control bundle.
package pipe_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_IWAIT = 2'd1,
        ST_DWAIT = 2'd2
    } state_e;

    localparam int unsigned MAX_WAIT_DEF = 255;

    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic id_ex_write;
        logic ex_mem_write;
        logic if_id_flush;
        logic id_ex_flush;
    } ctrl_t;

    localparam ctrl_t CTRL_FREEZE = 6'b000000;
    localparam ctrl_t CTRL_BRANCH = 6'b111111;
    localparam ctrl_t CTRL_LDUSE  = 6'b001101;
    localparam ctrl_t CTRL_ISTALL = 6'b001100;
    localparam ctrl_t CTRL_RUN    = 6'b111100;

    function automatic logic is_wait(state_e s);
        return s != ST_RUN;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller bundle: pipeline/memory status in, register enables out.
// master = pipeline side driving status, slave = hazard controller.
interface pipe_hazard_ctrl_if;
    import pipe_hazard_ctrl_pkg::*;

    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        id_use_rs1;
    logic        id_use_rs2;
    logic [4:0]  ex_rd;
    logic        ex_mem_read;
    logic        ex_branch_taken;
    logic        imem_req;
    logic        imem_ready;
    logic        dmem_req;
    logic        dmem_ready;

    logic        pc_write;
    logic        if_id_write;
    logic        id_ex_write;
    logic        ex_mem_write;
    logic        if_id_flush;
    logic        id_ex_flush;
    logic        istall;
    logic        dstall;
    logic        wait_err;
    logic [15:0] stall_cycles;
    state_e      state;
    logic [7:0]  wait_cnt;

    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd,
        output ex_mem_read, ex_branch_taken,
        output imem_req, imem_ready, dmem_req, dmem_ready,
        input  pc_write, if_id_write, id_ex_write, ex_mem_write,
        input  if_id_flush, id_ex_flush, istall, dstall,
        input  wait_err, stall_cycles, state, wait_cnt
    );

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd,
        input  ex_mem_read, ex_branch_taken,
        input  imem_req, imem_ready, dmem_req, dmem_ready,
        output pc_write, if_id_write, id_ex_write, ex_mem_write,
        output if_id_flush, id_ex_flush, istall, dstall,
        output wait_err, stall_cycles, state, wait_cnt
    );

endinterface

// File: rtl/stall_wdog.sv
// Memory-wait watchdog: counts cycles spent in a wait state, sets sticky err.
// Ports: clk, rst, state/state_nx (current/next FSM state), cnt, wait_err.
module stall_wdog
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int unsigned MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  state_e     state,
    input  state_e     state_nx,
    output logic [7:0] cnt,
    output logic       wait_err
);

    localparam logic [7:0] LIMIT = 8'(MAX_WAIT);

    logic [7:0] cnt_nx;
    logic       err_nx;

    // Any state change restarts the count, so DWAIT->IWAIT starts fresh.
    always_comb begin
        cnt_nx = cnt;
        if (state_nx != state) begin
            cnt_nx = '0;
        end else if (is_wait(state) && cnt != LIMIT) begin
            cnt_nx = cnt + 8'd1;
        end
        err_nx = wait_err | (cnt_nx == LIMIT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            wait_err <= 1'b0;
        end else begin
            cnt      <= cnt_nx;
            wait_err <= err_nx;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use, branch, I/D memory stall decisions.
// Ports: clk, rst, bus (slave side of pipe_hazard_ctrl_if).
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int unsigned MAX_WAIT = MAX_WAIT_DEF
) (
    input logic               clk,
    input logic               rst,
    pipe_hazard_ctrl_if.slave bus
);

    state_e      state;
    state_e      state_nx;
    logic        dstall;
    logic        imem_wait;
    logic        istall;
    logic        load_use;
    logic        sel_frz;
    logic        sel_br;
    logic        sel_lu;
    logic        sel_is;
    logic        redirect_pending;
    logic        redirect_done;
    logic        lu_hold;
    logic [15:0] stall_cycles;
    logic [7:0]  wait_cnt;
    logic        wait_err;
    ctrl_t       ctrl;

    always_comb begin
        dstall    = bus.dmem_req & ~bus.dmem_ready;
        imem_wait = bus.imem_req & ~bus.imem_ready;
        istall    = imem_wait & ~dstall;
        load_use  = bus.ex_mem_read & (bus.ex_rd != 5'd0)
                  & ((bus.id_use_rs1 & (bus.id_rs1 == bus.ex_rd))
                  |  (bus.id_use_rs2 & (bus.id_rs2 == bus.ex_rd)));
        // Mutually exclusive selects encode the priority order.
        sel_frz = rst | dstall;
        sel_br  = ~sel_frz & bus.ex_branch_taken;
        // lu_hold keeps a load-use bubble to a single cycle.
        sel_lu  = ~sel_frz & ~bus.ex_branch_taken & load_use & ~lu_hold;
        sel_is  = ~sel_frz & ~bus.ex_branch_taken & ~sel_lu & istall;
        redirect_done = redirect_pending & bus.imem_ready & ~dstall;
    end

    always_comb begin
        ctrl = CTRL_RUN;
        unique case (1'b1)
            sel_frz: ctrl = CTRL_FREEZE;
            sel_br:  ctrl = CTRL_BRANCH;
            sel_lu:  ctrl = CTRL_LDUSE;
            sel_is:  ctrl = CTRL_ISTALL;
            default: ctrl = CTRL_RUN;
        endcase
        // Late fetch data belongs to the wrong path after a redirect.
        if (redirect_done && !rst) begin
            ctrl.if_id_flush = 1'b1;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_RUN: begin
                if (dstall)      state_nx = ST_DWAIT;
                else if (istall) state_nx = ST_IWAIT;
            end
            ST_IWAIT: begin
                if (dstall)              state_nx = ST_DWAIT;
                else if (bus.imem_ready) state_nx = ST_RUN;
            end
            ST_DWAIT: begin
                if (bus.dmem_ready) begin
                    state_nx = imem_wait ? ST_IWAIT : ST_RUN;
                end
            end
            default: state_nx = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= ST_RUN;
            redirect_pending <= 1'b0;
            lu_hold          <= 1'b0;
            stall_cycles     <= '0;
        end else begin
            state   <= state_nx;
            lu_hold <= sel_lu | (dstall & lu_hold);
            if (sel_br && imem_wait) begin
                redirect_pending <= 1'b1;
            end else if (redirect_done) begin
                redirect_pending <= 1'b0;
            end
            if (!ctrl.pc_write && stall_cycles != 16'hFFFF) begin
                stall_cycles <= stall_cycles + 16'd1;
            end
        end
    end

    stall_wdog #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wdog (
        .clk      (clk),
        .rst      (rst),
        .state    (state),
        .state_nx (state_nx),
        .cnt      (wait_cnt),
        .wait_err (wait_err)
    );

    assign bus.pc_write     = ctrl.pc_write;
    assign bus.if_id_write  = ctrl.if_id_write;
    assign bus.id_ex_write  = ctrl.id_ex_write;
    assign bus.ex_mem_write = ctrl.ex_mem_write;
    assign bus.if_id_flush  = ctrl.if_id_flush;
    assign bus.id_ex_flush  = ctrl.id_ex_flush;
    assign bus.istall       = istall;
    assign bus.dstall       = dstall;
    assign bus.wait_err     = wait_err;
    assign bus.stall_cycles = stall_cycles;
    assign bus.state        = state;
    assign bus.wait_cnt     = wait_cnt;

endmodule
